display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 81 ++++++++
 tb/tb_display_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates three BCD display channels (two round-robin, one preemptive alert) onto one seven-segment driver
module display_scheduler #(
    parameter int HOLD_CYCLES = 50000,
    parameter int BLINK_HALF  = 12500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] bcd0,
    input  logic [15:0] bcd1,
    input  logic [15:0] bcd2,
    input  logic [3:0]  dot0,
    input  logic [3:0]  dot1,
    input  logic [3:0]  dot2,
    input  logic [2:0]  blink,
    output logic [15:0] BCD,
    output logic [3:0]  DOT,
    output logic        BI,
    output logic [2:0]  grant
);
    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1, ALERT} state_t;
    state_t state, state_nx, ret, ret_nx, other;
    logic [15:0] hold, hold_nx, bcnt, bcnt_nx;
    logic phase, phase_nx, expire, own, other_req;
    logic [2:0] grant_nx;
    // next-state arbitration, hold/blink timers and next grant
    always_comb begin
        state_nx  = state;
        ret_nx    = ret;
        other     = (state == SHOW0) ? SHOW1 : SHOW0;
        own       = (state == SHOW0) ? req[0] : req[1];
        other_req = (state == SHOW0) ? req[1] : req[0];
        expire    = hold == 16'(HOLD_CYCLES - 1);
        case (state)
            IDLE: begin
                state_nx = req[2] ? ALERT : req[0] ? SHOW0 : req[1] ? SHOW1 : IDLE;
                ret_nx   = SHOW0;
            end
            SHOW0, SHOW1: begin
                if (req[2]) begin
                    state_nx = ALERT;
                    ret_nx   = state;
                end else if ((expire || !own) && other_req) state_nx = other;
                else if (!own) state_nx = IDLE;
            end
            default: begin
                if (!req[2])
                    state_nx = (ret == SHOW0) ? (req[0] ? SHOW0 : req[1] ? SHOW1 : IDLE)
                                              : (req[1] ? SHOW1 : req[0] ? SHOW0 : IDLE);
            end
        endcase
        hold_nx  = (state_nx == state && !expire && (state == SHOW0 || state == SHOW1)) ? hold + 16'd1 : '0;
        grant_nx = state_nx == SHOW0 ? 3'b001 : state_nx == SHOW1 ? 3'b010 : state_nx == ALERT ? 3'b100 : 3'b000;
        bcnt_nx  = (grant_nx != grant || bcnt == 16'(BLINK_HALF - 1)) ? '0 : bcnt + 16'd1;
        phase_nx = (grant_nx != grant) ? 1'b0 : (bcnt == 16'(BLINK_HALF - 1)) ? ~phase : phase;
    end
    // state, timers and registered outputs reflecting the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ret   <= SHOW0;
            hold  <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
            grant <= 3'b000;
            BCD   <= '0;
            DOT   <= '0;
            BI    <= 1'b1;
        end else begin
            state <= state_nx;
            ret   <= ret_nx;
            hold  <= hold_nx;
            bcnt  <= bcnt_nx;
            phase <= phase_nx;
            grant <= grant_nx;
            BCD   <= state_nx == SHOW0 ? bcd0 : state_nx == SHOW1 ? bcd1 : state_nx == ALERT ? bcd2 : 16'h0;
            DOT   <= state_nx == SHOW0 ? dot0 : state_nx == SHOW1 ? dot1 : state_nx == ALERT ? dot2 : 4'h0;
            BI    <= (state_nx == IDLE) ? 1'b1 : (|(blink & grant_nx)) & phase_nx;
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: randomized and directed checks of display_scheduler against a channel-level reference model
module tb_display_scheduler;
    localparam int HOLD = 8;
    localparam int BH   = 3;
    logic        clk = 0, reset = 0;
    logic [2:0]  req = 0, blink = 0;
    logic [15:0] bcd0 = 0, bcd1 = 0, bcd2 = 0;
    logic [3:0]  dot0 = 0, dot1 = 0, dot2 = 0;
    logic [15:0] BCD;
    logic [3:0]  DOT;
    logic        BI;
    logic [2:0]  grant;
    int checks = 0, errors = 0;
    // model: channel on display (-1 idle), channel to return to after alert, cycles since last grant change
    int cur = -1, ret = 0, age = 0;
    logic [15:0] exp_bcd = 0;
    logic [3:0]  exp_dot = 0;
    logic        exp_bi = 1;
    logic [2:0]  exp_grant = 0;

    display_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset), .req(req),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
        .dot0(dot0), .dot1(dot1), .dot2(dot2),
        .blink(blink), .BCD(BCD), .DOT(DOT), .BI(BI), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset;
        cur = -1; ret = 0; age = 0;
        exp_grant = 0; exp_bcd = 0; exp_dot = 0; exp_bi = 1;
    endtask

    task automatic step_model;
        int nxt;
        int o;
        nxt = cur;
        if (cur < 0) begin
            if (req[2]) begin nxt = 2; ret = 0; end
            else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
        end else if (cur < 2) begin
            o = 1 - cur;
            if (req[2]) begin nxt = 2; ret = cur; end
            else if (((age % HOLD) == HOLD - 1 || !req[cur]) && req[o]) nxt = o;
            else if (!req[cur]) nxt = -1;
        end else if (!req[2]) begin
            nxt = req[ret] ? ret : req[1 - ret] ? 1 - ret : -1;
        end
        age = (nxt == cur) ? age + 1 : 0;
        cur = nxt;
        exp_grant = (cur < 0) ? 3'b000 : 3'(1 << cur);
        case (cur)
            0: begin exp_bcd = bcd0; exp_dot = dot0; end
            1: begin exp_bcd = bcd1; exp_dot = dot1; end
            2: begin exp_bcd = bcd2; exp_dot = dot2; end
            default: begin exp_bcd = 0; exp_dot = 0; end
        endcase
        exp_bi = (cur < 0) ? 1'b1 : (blink[cur] && ((age / BH) % 2 == 1));
    endtask

    task automatic compare_all;
        check("grant", 32'(grant), 32'(exp_grant));
        check("bcd", 32'(BCD), 32'(exp_bcd));
        check("dot", 32'(DOT), 32'(exp_dot));
        check("bi", 32'(BI), 32'(exp_bi));
    endtask

    task automatic tick(input logic [2:0] r, input bit rnd);
        req = r;
        if (rnd) begin
            bcd0 = 16'($urandom); bcd1 = 16'($urandom); bcd2 = 16'($urandom);
            dot0 = 4'($urandom); dot1 = 4'($urandom); dot2 = 4'($urandom);
            blink = 3'($urandom);
        end
        @(posedge clk);
        step_model();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [2:0] r;
        bit found;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_bi", 32'(BI), 1);
        check("rst_bcd", 32'(BCD), 0);
        reset = 1;
        model_reset();
        for (int i = 0; i < 10; i++) tick(3'b000, 1'b1);
        check("idle_bcd", 32'(BCD), 0);
        bcd0 = 16'h1234; bcd1 = 16'h5678; bcd2 = 16'h9999; blink = 0;
        for (int i = 0; i < 8; i++) begin
            tick(3'b011, 1'b0);
            check("rr_g0", 32'(grant), 1);
            check("rr_b0", 32'(BCD), 32'h1234);
        end
        for (int i = 0; i < 4; i++) begin
            tick(3'b011, 1'b0);
            check("rr_g1", 32'(grant), 2);
            check("rr_b1", 32'(BCD), 32'h5678);
        end
        for (int i = 0; i < 5; i++) begin
            tick(3'b111, 1'b0);
            check("alert_g", 32'(grant), 4);
            check("alert_b", 32'(BCD), 32'h9999);
        end
        for (int i = 0; i < 8; i++) begin
            tick(3'b011, 1'b0);
            check("ret_g1", 32'(grant), 2);
        end
        tick(3'b011, 1'b0);
        check("ret_rot", 32'(grant), 1);
        tick(3'b000, 1'b0);
        blink = 3'b001;
        for (int i = 0; i < 14; i++) begin
            tick(3'b001, 1'b0);
            check("blink_g", 32'(grant), 1);
            check("blink_bi", 32'(BI), 32'((i / 3) % 2));
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cur == 0 && age % HOLD == HOLD - 1) found = 1;
            else tick(3'b011, 1'b1);
        end
        check("reach_exp1", 32'(found), 1);
        tick(3'b010, 1'b1);
        check("drop_exp_other", 32'(grant), 2);
        tick(3'b000, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cur == 0 && age % HOLD == HOLD - 1) found = 1;
            else tick(3'b001, 1'b1);
        end
        check("reach_exp2", 32'(found), 1);
        tick(3'b000, 1'b1);
        check("drop_exp_idle_g", 32'(grant), 0);
        check("drop_exp_idle_bi", 32'(BI), 1);
        r = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) r = 3'($urandom);
            tick(r, 1'b1);
        end
        for (int i = 0; i < 3; i++) tick(3'b100, 1'b1);
        check("pre_rst_alert", 32'(grant), 4);
        #2 reset = 0;
        #1;
        check("arst_grant", 32'(grant), 0);
        check("arst_bi", 32'(BI), 1);
        check("arst_bcd", 32'(BCD), 0);
        check("arst_dot", 32'(DOT), 0);
        model_reset();
        @(negedge clk);
        check("arst_hold", 32'(grant), 0);
        reset = 1;
        tick(3'b100, 1'b1);
        check("rel_alert", 32'(grant), 4);
        tick(3'b001, 1'b1);
        check("rel_ret0", 32'(grant), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
